// File: rtl/dec_stage_pkg.sv
// Shared types for the decoder/encoder stage pair: code width helper,
// default-width result entry and FIFO occupancy states.
package dec_stage_pkg;

    function automatic int unsigned code_w(input int unsigned width);
        return $clog2(width);
    endfunction

    localparam int unsigned DEF_WIDTH  = 8;
    localparam int unsigned DEF_CODE_W = code_w(DEF_WIDTH);

    typedef struct packed {
        logic [DEF_CODE_W-1:0] code;
        logic                  err;
    } enc_entry_t;

    typedef enum logic [1:0] {
        EMPTY,
        MID,
        FULL
    } occ_state_t;

endpackage

// File: rtl/onehot_fifo.sv
// Synchronous FIFO with occupancy FSM (EMPTY/MID/FULL); when empty the output
// holds the last entry popped.
module onehot_fifo
    import dec_stage_pkg::*;
#(
    parameter int unsigned DW    = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    occ_state_t      state, state_next;
    logic [CW-1:0]   count_next;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [DW-1:0]   mem [DEPTH];
    logic [DW-1:0]   last;
    logic            do_push, do_pop;

    assign do_push = push && (state != FULL);
    assign do_pop  = pop  && (state != EMPTY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)
            count_next = count + CW'(1);
        else if (do_pop && !do_push)
            count_next = count - CW'(1);
        if (count_next == '0)
            state_next = EMPTY;
        else if (count_next == CW'(DEPTH))
            state_next = FULL;
        else
            state_next = MID;
    end

    always_comb begin
        full  = (state == FULL);
        empty = (state == EMPTY);
        dout  = empty ? last : mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last   <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last   <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/onehot_encode_stage.sv
// One-hot to binary encoder with legality check, saturating error counter and
// result FIFO. Define ONEHOT_STATS_EN to add per-code hit counters (hit_cnt).
module onehot_encode_stage
    import dec_stage_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            in_y,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [code_w(WIDTH)-1:0]    out_code,
    output logic                        out_err,
    output logic [ERR_CNT_W-1:0]        err_cnt,
`ifdef ONEHOT_STATS_EN
    output logic [WIDTH*16-1:0]         hit_cnt,
`endif
    input  logic                        clr_cnt
);

    localparam int unsigned CODE_W = code_w(WIDTH);

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              err;
    } enc_t;

    enc_t                  enc, head;
    logic                  found;
    logic                  accept, pop;
    logic                  full, empty;
    logic [$clog2(DEPTH):0] count;

    // Lowest set bit wins so multi-hot words still yield a deterministic code.
    always_comb begin
        enc.code = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (in_y[i] && !found) begin
                enc.code = CODE_W'(i);
                found    = 1'b1;
            end
        end
        enc.err = (in_y == '0) || ((in_y & (in_y - WIDTH'(1))) != '0);
    end

    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_code  = head.code;
    assign out_err   = head.err;

    onehot_fifo #(
        .DW    ($bits(enc_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (enc),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_cnt <= '0;
        else if (clr_cnt)
            err_cnt <= '0;
        else if (accept && enc.err && (err_cnt != '1))
            err_cnt <= err_cnt + ERR_CNT_W'(1);
    end

`ifdef ONEHOT_STATS_EN
    logic [15:0] hits [WIDTH];

    for (genvar g = 0; g < WIDTH; g++) begin : g_hit
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                hits[g] <= '0;
            else if (clr_cnt)
                hits[g] <= '0;
            else if (accept && !enc.err && (enc.code == CODE_W'(g)) && (hits[g] != '1))
                hits[g] <= hits[g] + 16'd1;
        end
        assign hit_cnt[g*16 +: 16] = hits[g];
    end
`endif

endmodule

// File: tb/tb_onehot_encode_stage.sv
// Directed self-checking bench for onehot_encode_stage (WIDTH=8, DEPTH=4, ERR_CNT_W=8).
module tb_onehot_encode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_y;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_code;
    logic        out_err;
    logic [7:0]  err_cnt;
    logic        clr_cnt;
`ifdef ONEHOT_STATS_EN
    logic [127:0] hit_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    onehot_encode_stage #(
        .WIDTH     (8),
        .DEPTH     (4),
        .ERR_CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_err   (out_err),
        .err_cnt   (err_cnt),
`ifdef ONEHOT_STATS_EN
        .hit_cnt   (hit_cnt),
`endif
        .clr_cnt   (clr_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_valid  = 1'b0;
        in_y      = '0;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++;
        if (out_code !== 3'd0) begin n_fail++; $display("FAIL reset_out_code got %0d want 0", out_code); end
        n_checks++;
        if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err got %b want 0", out_err); end
        n_checks++;
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    endtask

    task automatic test_mid_reset;
        logic seen;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_y = 8'h00; tick();
        in_y = 8'h04; tick();
        in_y = 8'h10; tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || err_cnt !== 8'd1) begin
            n_fail++; $display("FAIL midrst_pre got valid=%b err_cnt=%0d want 1/1", out_valid, err_cnt);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
        n_checks++;
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_err_cnt got %0d want 0", err_cnt); end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_survivor got out_valid seen=%b want 0", seen); end
    endtask

    task automatic test_walk;
        logic [2:0] exp;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_y     = 8'h01 << i;
            exp      = 3'(i);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_code !== exp || out_err !== 1'b0) begin
                n_fail++;
                $display("FAIL walk_%0d got v=%b code=%0d err=%b want v=1 code=%0d err=0",
                         i, out_valid, out_code, out_err, exp);
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL walk_drain got %b want 0", out_valid); end
    endtask

    task automatic test_illegal;
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_y = 8'h00; tick();
        in_y = 8'h24; tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_code !== 3'd0 || out_err !== 1'b1) begin
            n_fail++; $display("FAIL illegal_zero got code=%0d err=%b want 0/1", out_code, out_err);
        end
        n_checks++;
        if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL illegal_err_cnt got %0d want 2", err_cnt); end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_code !== 3'd2 || out_err !== 1'b1) begin
            n_fail++; $display("FAIL illegal_multi got v=%b code=%0d err=%b want 1/2/1", out_valid, out_code, out_err);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_code !== 3'd2 || out_err !== 1'b1) begin
            n_fail++; $display("FAIL illegal_hold got v=%b code=%0d err=%b want 0/2/1", out_valid, out_code, out_err);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [5];
        logic [2:0] codes [5];
        int         pushes, pops;
        logic       acc, pp, both;
        words = '{8'h02, 8'h08, 8'h20, 8'h80, 8'h04};
        codes = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2};
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_y     = words[k];
            tick();
        end
        in_y = words[4];
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full got in_ready=%b want 0", in_ready); end
        tick();
        n_checks++;
        if (out_code !== 3'd1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_stall got code=%0d in_ready=%b want 1/0", out_code, in_ready);
        end
        out_ready = 1'b1;
        pushes = 4;
        pops   = 0;
        both   = 1'b0;
        for (int cyc = 0; cyc < 30 && pops < 5; cyc++) begin
            acc = in_valid && in_ready;
            pp  = out_valid && out_ready;
            if (pp) begin
                n_checks++;
                if (out_code !== codes[pops] || out_err !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_order_%0d got code=%0d err=%b want %0d/0",
                                       pops, out_code, out_err, codes[pops]);
                end
                pops++;
            end
            if (acc && pp) both = 1'b1;
            tick();
            if (acc) begin
                pushes++;
                if (pushes == 5) in_valid = 1'b0;
            end
        end
        n_checks++;
        if (pops != 5) begin n_fail++; $display("FAIL b2b_timeout got pops=%0d want 5", pops); end
        n_checks++;
        if (both !== 1'b1) begin n_fail++; $display("FAIL b2b_pushpop got %b want 1", both); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_extra got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_saturate;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_y      = 8'h00;
        for (int i = 0; i < 254; i++) tick();
        n_checks++;
        if (err_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254 got %0d want 254", err_cnt); end
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold got %0d want 255", err_cnt); end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        n_checks++;
        if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_clr got %0d want 0", err_cnt); end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL sat_restart got %0d want 1", err_cnt); end
    endtask

`ifdef ONEHOT_STATS_EN
    task automatic test_stats;
        logic [15:0] exp;
        logic        bad;
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_y = 8'h08; tick();
        in_y = 8'h08; tick();
        in_y = 8'h08; tick();
        in_y = 8'h18; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = (i == 3) ? 16'd3 : 16'd0;
            n_checks++;
            if (hit_cnt[i*16 +: 16] !== exp) begin
                n_fail++; $display("FAIL stats_hit_%0d got %0d want %0d", i, hit_cnt[i*16 +: 16], exp);
            end
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        bad = (hit_cnt !== '0);
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL stats_clr got %h want 0", hit_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_mid_reset();
        test_walk();
        test_illegal();
        test_back_to_back();
        test_saturate();
`ifdef ONEHOT_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
